// File: rtl/direct_mapped_cache_if.sv
// CPU-side and memory-side signal bundle of the direct-mapped cache.
// The slave modport is the cache; the master modport is its environment (CPU + memory).
interface direct_mapped_cache_if #(
  parameter int WORD_SIZE = 16
);
  logic                 cpu_read;
  logic                 cpu_write;
  logic [WORD_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic [WORD_SIZE-1:0] cpu_rdata;
  logic                 cpu_ready;
  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ack;
  logic [WORD_SIZE-1:0] num_access;
  logic [WORD_SIZE-1:0] num_miss;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata,
           num_access, num_miss
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata,
           num_access, num_miss
  );
endinterface

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with word-by-word refill.
// Read hits complete combinationally; misses and all writes stall the CPU.
module direct_mapped_cache #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  direct_mapped_cache_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t                                           r_state;
  logic [NUM_LINES-1:0]                             r_valid;
  logic [NUM_LINES-1:0][TAG_W-1:0]                  r_tag;
  logic [NUM_LINES-1:0][LINE_WORDS-1:0][WORD_SIZE-1:0] r_data;
  logic [OFF_W-1:0]                                 r_cnt;
  logic                                             r_mem_read;
  logic                                             r_mem_write;
  logic [WORD_SIZE-1:0]                             r_mem_addr;
  logic [WORD_SIZE-1:0]                             r_mem_wdata;
  logic [WORD_SIZE-1:0]                             r_num_access;
  logic [WORD_SIZE-1:0]                             r_num_miss;

  logic [TAG_W-1:0]     w_tag;
  logic [IDX_W-1:0]     w_idx;
  logic [OFF_W-1:0]     w_off;
  logic [OFF_W-1:0]     w_cnt_nxt;
  logic                 w_hit;
  logic                 w_last;
  logic                 w_rd_hit;
  logic                 w_wr_done;
  logic                 w_ready;
  logic [WORD_SIZE-1:0] w_word;

  assign {w_tag, w_idx, w_off} = bus.cpu_addr;
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_word    = r_data[w_idx][w_off];
  assign w_cnt_nxt = r_cnt + OFF_W'(1);
  assign w_last    = (r_cnt == OFF_W'(LINE_WORDS - 1));
  // A write outranks a simultaneous read, so a read only hits when no write is pending.
  assign w_rd_hit  = (r_state == IDLE) && bus.cpu_read && !bus.cpu_write && w_hit;
  assign w_wr_done = (r_state == WRITE) && bus.mem_ack;
  assign w_ready   = w_rd_hit || w_wr_done;

  assign bus.cpu_ready  = w_ready;
  assign bus.cpu_rdata  = w_rd_hit ? w_word : '0;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.num_access = r_num_access;
  assign bus.num_miss   = r_num_miss;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_tag        <= '0;
      r_cnt        <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_num_access <= '0;
      r_num_miss   <= '0;
    end else begin
      if (w_ready) r_num_access <= r_num_access + WORD_SIZE'(1);
      case (r_state)
        IDLE: begin
          if (bus.cpu_write) begin
            r_state     <= WRITE;
            r_mem_write <= 1'b1;
            r_mem_addr  <= bus.cpu_addr;
            r_mem_wdata <= bus.cpu_wdata;
          end else if (bus.cpu_read && !w_hit) begin
            r_state    <= REFILL;
            r_mem_read <= 1'b1;
            r_cnt      <= '0;
            r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
            r_num_miss <= r_num_miss + WORD_SIZE'(1);
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              // The line only becomes valid once every word has landed.
              r_valid[w_idx] <= 1'b1;
              r_tag[w_idx]   <= w_tag;
              r_mem_read     <= 1'b0;
              r_mem_addr     <= '0;
              r_state        <= IDLE;
            end else begin
              r_mem_addr <= {w_tag, w_idx, w_cnt_nxt};
            end
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data words carry no reset; validity is tracked by r_valid alone.
  always_ff @(posedge Clk) begin
    if (r_state == REFILL && bus.mem_ack)
      r_data[w_idx][r_cnt] <= bus.mem_rdata;
    else if (w_wr_done && w_hit)
      r_data[w_idx][w_off] <= bus.cpu_wdata;
  end
endmodule

// File: tb/tb_direct_mapped_cache.sv
// Directed bench for direct_mapped_cache: vector table plus cold-read, held-read and reset-mid-refill sequences.
module tb_direct_mapped_cache;
  logic Clk = 1'b0;
  logic Reset_N = 1'b0;
  always #5 Clk = ~Clk;

  direct_mapped_cache_if #(.WORD_SIZE(16)) bus();

  direct_mapped_cache #(.WORD_SIZE(16), .LINE_WORDS(4), .NUM_LINES(4)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .bus(bus)
  );

  // Memory model: latches a request one cycle, acks it the next (ack in the 2nd cycle of each request).
  logic [15:0] mem [0:2047];
  logic [15:0] rlog [$];
  int          n_rd_xfer = 0;
  int          n_wr_xfer = 0;
  logic [15:0] last_waddr, last_wdata;
  logic        pend, p_we;
  logic [15:0] p_addr, p_wd;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'hA000 ^ 16'(i);
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    pend = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0;
    last_waddr = '0; last_wdata = '0;
    forever begin
      @(posedge Clk); #1;
      bus.mem_ack = 1'b0;
      if (pend) begin
        bus.mem_ack = 1'b1;
        pend = 1'b0;
        if (p_we) begin
          mem[p_addr[10:0]] = p_wd;
          n_wr_xfer++;
          last_waddr = p_addr; last_wdata = p_wd;
        end else begin
          bus.mem_rdata = mem[p_addr[10:0]];
          n_rd_xfer++;
          rlog.push_back(p_addr);
        end
      end else if (bus.mem_read || bus.mem_write) begin
        pend = 1'b1; p_we = bus.mem_write; p_addr = bus.mem_addr; p_wd = bus.mem_wdata;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Caller is at posedge+2; request is presented at once and dropped at posedge+2 after cpu_ready.
  task automatic access(input logic we, input logic re, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output int lat, output int ops);
    int  r0, w0;
    bit  ok, both;
    r0 = n_rd_xfer; w0 = n_wr_xfer; ok = 0; both = 0; lat = -1; rd = '0;
    bus.cpu_write = we; bus.cpu_read = re; bus.cpu_addr = a; bus.cpu_wdata = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (bus.mem_read && bus.mem_write) both = 1;
      if (bus.cpu_ready) begin rd = bus.cpu_rdata; lat = c; ok = 1; break; end
    end
    chk("ready_seen", 32'(ok), 32'd1);
    chk("rd_wr_exclusive", 32'(both), 32'd0);
    @(posedge Clk); #2;
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    ops = (n_rd_xfer - r0) + (n_wr_xfer - w0);
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          exp_lat;
    logic [15:0] exp_acc;
    logic [15:0] exp_miss;
    int          exp_ops;
  } vec_t;

  vec_t vt [18];

  initial begin
    logic [15:0] rd;
    int lat, ops, b, a0;
    bit ok;
    vt[0]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hA010, 0, 16'd2,  16'd1, 0};
    vt[1]  = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'hA011, 0, 16'd3,  16'd1, 0};
    vt[2]  = '{1'b0, 1'b1, 16'h0013, 16'h0000, 16'hA013, 0, 16'd4,  16'd1, 0};
    vt[3]  = '{1'b1, 1'b0, 16'h0011, 16'hBEEF, 16'h0000, 2, 16'd5,  16'd1, 1};
    vt[4]  = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'hBEEF, 0, 16'd6,  16'd1, 0};
    vt[5]  = '{1'b1, 1'b0, 16'h0420, 16'h1234, 16'h0000, 2, 16'd7,  16'd1, 1};
    vt[6]  = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'hBEEF, 0, 16'd8,  16'd1, 0};
    vt[7]  = '{1'b0, 1'b1, 16'h0420, 16'h0000, 16'h1234, 9, 16'd9,  16'd2, 4};
    vt[8]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hA010, 9, 16'd10, 16'd3, 4};
    vt[9]  = '{1'b0, 1'b1, 16'h0050, 16'h0000, 16'hA050, 9, 16'd11, 16'd4, 4};
    vt[10] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hA010, 9, 16'd12, 16'd5, 4};
    vt[11] = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'hBEEF, 0, 16'd13, 16'd5, 0};
    vt[12] = '{1'b0, 1'b1, 16'h0024, 16'h0000, 16'hA024, 9, 16'd14, 16'd6, 4};
    vt[13] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hA010, 0, 16'd15, 16'd6, 0};
    vt[14] = '{1'b1, 1'b0, 16'h0027, 16'h5555, 16'h0000, 2, 16'd16, 16'd6, 1};
    vt[15] = '{1'b0, 1'b1, 16'h0027, 16'h0000, 16'h5555, 0, 16'd17, 16'd6, 0};
    vt[16] = '{1'b1, 1'b1, 16'h0026, 16'h7777, 16'h0000, 2, 16'd18, 16'd6, 1};
    vt[17] = '{1'b0, 1'b1, 16'h0026, 16'h0000, 16'h7777, 0, 16'd19, 16'd6, 0};

    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    repeat (2) @(posedge Clk); #2;
    chk("rst_cpu_ready",  32'(bus.cpu_ready),  32'd0);
    chk("rst_cpu_rdata",  32'(bus.cpu_rdata),  32'd0);
    chk("rst_mem_read",   32'(bus.mem_read),   32'd0);
    chk("rst_mem_write",  32'(bus.mem_write),  32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    chk("rst_num_access", 32'(bus.num_access), 32'd0);
    chk("rst_num_miss",   32'(bus.num_miss),   32'd0);
    Reset_N = 1'b1;
    @(posedge Clk); #2;

    // Cold read of 0x0012: refill 0x10..0x13, ready in cycle 9.
    b = rlog.size();
    access(1'b0, 1'b1, 16'h0012, 16'h0000, rd, lat, ops);
    chk("cold_rdata", 32'(rd), 32'hA012);
    chk("cold_latency", 32'(lat), 32'd9);
    chk("cold_nwords", 32'(rlog.size() - b), 32'd4);
    for (int k = 0; k < 4; k++)
      if (rlog.size() > b + k) chk($sformatf("cold_refill_addr%0d", k), 32'(rlog[b+k]), 32'h10 + 32'(k));
    chk("cold_num_miss", 32'(bus.num_miss), 32'd1);
    chk("cold_num_access", 32'(bus.num_access), 32'd1);

    for (int i = 0; i < 18; i++) begin
      access(vt[i].we, vt[i].re, vt[i].addr, vt[i].wdata, rd, lat, ops);
      if (!vt[i].we) chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(vt[i].exp_rd));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("v%0d_mem_ops", i), 32'(ops), 32'(vt[i].exp_ops));
      chk($sformatf("v%0d_num_access", i), 32'(bus.num_access), 32'(vt[i].exp_acc));
      chk($sformatf("v%0d_num_miss", i), 32'(bus.num_miss), 32'(vt[i].exp_miss));
      if (vt[i].we) begin
        chk($sformatf("v%0d_mem_waddr", i), 32'(last_waddr), 32'(vt[i].addr));
        chk($sformatf("v%0d_mem_wdata", i), 32'(last_wdata), 32'(vt[i].wdata));
      end
    end

    // Held read: three hit cycles count three accesses.
    a0 = int'(bus.num_access);
    bus.cpu_read = 1'b1; bus.cpu_addr = 16'h0010;
    @(negedge Clk);
    chk("held_ready", 32'(bus.cpu_ready), 32'd1);
    chk("held_rdata", 32'(bus.cpu_rdata), 32'hA010);
    repeat (3) @(posedge Clk); #2;
    bus.cpu_read = 1'b0;
    chk("held_access_delta", 32'(int'(bus.num_access) - a0), 32'd3);
    @(negedge Clk);
    chk("idle_rdata_zero", 32'(bus.cpu_rdata), 32'd0);
    @(posedge Clk); #2;

    // Reset during the third refill word of a miss to 0x0052; the read stays held.
    bus.cpu_read = 1'b1; bus.cpu_addr = 16'h0052;
    repeat (5) @(posedge Clk);
    #3;
    chk("mid_mem_read_before", 32'(bus.mem_read), 32'd1);
    chk("mid_mem_addr_before", 32'(bus.mem_addr), 32'h52);
    Reset_N = 1'b0;
    #1;
    chk("mid_rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("mid_rst_num_access", 32'(bus.num_access), 32'd0);
    chk("mid_rst_num_miss", 32'(bus.num_miss), 32'd0);
    chk("mid_rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_N = 1'b1;
    b = rlog.size();
    ok = 0; lat = -1; rd = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (bus.cpu_ready) begin rd = bus.cpu_rdata; lat = c; ok = 1; break; end
    end
    chk("reread_ready_seen", 32'(ok), 32'd1);
    chk("reread_latency", 32'(lat), 32'd8);
    chk("reread_rdata", 32'(rd), 32'hA052);
    @(posedge Clk); #2;
    bus.cpu_read = 1'b0;
    chk("reread_nwords", 32'(rlog.size() - b), 32'd4);
    for (int k = 0; k < 4; k++)
      if (rlog.size() > b + k) chk($sformatf("reread_refill_addr%0d", k), 32'(rlog[b+k]), 32'h50 + 32'(k));
    chk("reread_num_miss", 32'(bus.num_miss), 32'd1);
    chk("reread_num_access", 32'(bus.num_access), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
